// File: rtl/trap_if.sv
// Execute-stage event, CSR and fetch-control signals between the core and trap_ctrl.
interface trap_if;
    logic        instr_valid_i;
    logic [31:0] instr_pc_i;
    logic        illegal_i;
    logic        ecall_i;
    logic        mret_i;
    logic        irq_i;
    logic        mie_i;
    logic [31:0] epc_i;
    logic        kill_o;
    logic        save_epc_o;
    logic [31:0] epc_pc_o;
    logic [31:0] mcause_o;
    logic        flush_o;
    logic        stall_o;
    logic        pc_redirect_o;
    logic [31:0] pc_target_o;

    modport master (
        output instr_valid_i, instr_pc_i, illegal_i, ecall_i, mret_i, irq_i, mie_i, epc_i,
        input  kill_o, save_epc_o, epc_pc_o, mcause_o, flush_o, stall_o,
               pc_redirect_o, pc_target_o
    );

    modport slave (
        input  instr_valid_i, instr_pc_i, illegal_i, ecall_i, mret_i, irq_i, mie_i, epc_i,
        output kill_o, save_epc_o, epc_pc_o, mcause_o, flush_o, stall_o,
               pc_redirect_o, pc_target_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: kills the trapping instruction, strobes EPC save,
// records mcause and redirects fetch to the trap vector or to mepc on mret.
//   state  | meaning
//   IDLE   | watching the execute stage for traps and mret
//   SAVE   | EPC-save strobe to the CSR unit, pipeline flushed
//   VECTOR | redirect fetch to MTVEC
//   RET    | redirect fetch to the latched mepc
module trap_ctrl #(
    parameter logic [31:0] MTVEC     = 32'h0000_0100,
    parameter logic [31:0] IRQ_CAUSE = 32'h8000_000B
) (
    input logic clk,
    input logic rst_n,
    trap_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SAVE, VECTOR, RET} state_e;

    state_e      state_q, state_d;
    logic        trap_req, mret_req, irq_take;
    logic [31:0] cause;

    logic        save_epc_q, save_epc_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [31:0] epc_pc_q, epc_pc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] pc_target_q, pc_target_d;

    // Interrupts only ride on a valid instruction so the saved EPC is never stale.
    assign irq_take = bus.irq_i & bus.mie_i;
    assign trap_req = (state_q == IDLE) & bus.instr_valid_i
                    & (irq_take | bus.illegal_i | bus.ecall_i);
    assign mret_req = (state_q == IDLE) & bus.instr_valid_i & bus.mret_i & ~trap_req;

    always_comb begin
        if (irq_take)           cause = IRQ_CAUSE;
        else if (bus.illegal_i) cause = 32'd2;
        else                    cause = 32'd11;
    end

    always_comb begin
        state_d     = state_q;
        epc_pc_d    = epc_pc_q;
        mcause_d    = mcause_q;
        pc_target_d = pc_target_q;
        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    state_d  = SAVE;
                    epc_pc_d = bus.instr_pc_i;
                    mcause_d = cause;
                end else if (mret_req) begin
                    state_d     = RET;
                    pc_target_d = bus.epc_i;
                end
            end
            SAVE: begin
                state_d     = VECTOR;
                pc_target_d = MTVEC;
            end
            VECTOR:  state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes are registered copies of the state being entered.
        save_epc_d = (state_d == SAVE);
        redirect_d = (state_d == VECTOR) || (state_d == RET);
        flush_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            save_epc_q  <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            epc_pc_q    <= 32'd0;
            mcause_q    <= 32'd0;
            pc_target_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            save_epc_q  <= save_epc_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            epc_pc_q    <= epc_pc_d;
            mcause_q    <= mcause_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign bus.kill_o        = trap_req;
    assign bus.save_epc_o    = save_epc_q;
    assign bus.epc_pc_o      = epc_pc_q;
    assign bus.mcause_o      = mcause_q;
    assign bus.flush_o       = flush_q;
    assign bus.stall_o       = flush_q;
    assign bus.pc_redirect_o = redirect_q;
    assign bus.pc_target_o   = pc_target_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, trap sequencing, priorities, mret and mid-sequence reset.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] IRQC = 32'h8000_000B;

    trap_if tif ();
    trap_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(tif));

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] pc, input logic ill,
                         input logic ec, input logic mr, input logic irq, input logic mie);
        tif.instr_valid_i = v;
        tif.instr_pc_i    = pc;
        tif.illegal_i     = ill;
        tif.ecall_i       = ec;
        tif.mret_i        = mr;
        tif.irq_i         = irq;
        tif.mie_i         = mie;
    endtask

    task automatic quiet();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tif.epc_i = 32'd0;
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tif.save_epc_o, tif.flush_o, tif.stall_o, tif.pc_redirect_o} !== 4'b0000) begin
                n_fail++; $display("FAIL reset_strobes got %b want 0000",
                    {tif.save_epc_o, tif.flush_o, tif.stall_o, tif.pc_redirect_o});
            end
            n_checks++;
            if ({tif.epc_pc_o, tif.mcause_o, tif.pc_target_o} !== 96'd0) begin
                n_fail++; $display("FAIL reset_regs got %h %h %h want 0",
                    tif.epc_pc_o, tif.mcause_o, tif.pc_target_o);
            end
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b1) begin n_fail++; $display("FAIL reset_first_kill got %b want 1", tif.kill_o); end
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.save_epc_o !== 1'b1 || tif.epc_pc_o !== 32'h10 || tif.mcause_o !== IRQC) begin
            n_fail++; $display("FAIL reset_first_trap got save=%b epc=%h cause=%h want 1 10 %h",
                tif.save_epc_o, tif.epc_pc_o, tif.mcause_o, IRQC);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b1 || tif.save_epc_o !== 1'b0) begin
            n_fail++; $display("FAIL ill_T got kill=%b save=%b want 1 0", tif.kill_o, tif.save_epc_o);
        end
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.save_epc_o !== 1'b1 || tif.epc_pc_o !== 32'h40 || tif.mcause_o !== 32'd2
            || tif.flush_o !== 1'b1 || tif.stall_o !== 1'b1 || tif.pc_redirect_o !== 1'b0) begin
            n_fail++; $display("FAIL ill_T1 got save=%b epc=%h cause=%h fl=%b st=%b rd=%b want 1 40 2 1 1 0",
                tif.save_epc_o, tif.epc_pc_o, tif.mcause_o, tif.flush_o, tif.stall_o, tif.pc_redirect_o);
        end
        @(negedge clk);
        n_checks++;
        if (tif.pc_redirect_o !== 1'b1 || tif.pc_target_o !== 32'h100 || tif.save_epc_o !== 1'b0
            || tif.flush_o !== 1'b1 || tif.stall_o !== 1'b1) begin
            n_fail++; $display("FAIL ill_T2 got rd=%b tgt=%h save=%b fl=%b st=%b want 1 100 0 1 1",
                tif.pc_redirect_o, tif.pc_target_o, tif.save_epc_o, tif.flush_o, tif.stall_o);
        end
        @(negedge clk);
        n_checks++;
        if (tif.pc_redirect_o !== 1'b0 || tif.flush_o !== 1'b0 || tif.stall_o !== 1'b0
            || tif.pc_target_o !== 32'h100) begin
            n_fail++; $display("FAIL ill_T3 got rd=%b fl=%b st=%b tgt=%h want 0 0 0 100",
                tif.pc_redirect_o, tif.flush_o, tif.stall_o, tif.pc_target_o);
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.mcause_o !== IRQC || tif.epc_pc_o !== 32'h80) begin
            n_fail++; $display("FAIL irq_vs_ecall got cause=%h epc=%h want %h 80", tif.mcause_o, tif.epc_pc_o, IRQC);
        end
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.mcause_o !== 32'd11 || tif.save_epc_o !== 1'b1) begin
            n_fail++; $display("FAIL masked_ecall got cause=%h save=%b want b 1", tif.mcause_o, tif.save_epc_o);
        end
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 32'h90, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.mcause_o !== 32'd2 || tif.epc_pc_o !== 32'h90) begin
            n_fail++; $display("FAIL ill_vs_ecall_none got cause=%h epc=%h want 2 90", tif.mcause_o, tif.epc_pc_o);
        end
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 32'h94, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.mcause_o !== IRQC) begin
            n_fail++; $display("FAIL irq_vs_illegal got cause=%h want %h", tif.mcause_o, IRQC);
        end
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b0) begin n_fail++; $display("FAIL masked_irq_kill got %b want 0", tif.kill_o); end
        drive(1'b0, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b0) begin n_fail++; $display("FAIL irq_novalid_kill got %b want 0", tif.kill_o); end
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.save_epc_o !== 1'b0 || tif.flush_o !== 1'b0 || tif.mcause_o !== IRQC) begin
            n_fail++; $display("FAIL irq_novalid_seq got save=%b fl=%b cause=%h want 0 0 %h",
                tif.save_epc_o, tif.flush_o, tif.mcause_o, IRQC);
        end
    endtask

    task automatic test_mret();
        tif.epc_i = 32'h84;
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b0) begin n_fail++; $display("FAIL mret_kill got %b want 0", tif.kill_o); end
        @(negedge clk);
        quiet();
        tif.epc_i = 32'hDEAD_BEEF;
        n_checks++;
        if (tif.pc_redirect_o !== 1'b1 || tif.pc_target_o !== 32'h84 || tif.save_epc_o !== 1'b0
            || tif.flush_o !== 1'b1 || tif.stall_o !== 1'b1) begin
            n_fail++; $display("FAIL mret_T1 got rd=%b tgt=%h save=%b fl=%b st=%b want 1 84 0 1 1",
                tif.pc_redirect_o, tif.pc_target_o, tif.save_epc_o, tif.flush_o, tif.stall_o);
        end
        @(negedge clk);
        n_checks++;
        if (tif.pc_redirect_o !== 1'b0 || tif.pc_target_o !== 32'h84 || tif.save_epc_o !== 1'b0
            || tif.flush_o !== 1'b0 || tif.epc_pc_o !== 32'h94) begin
            n_fail++; $display("FAIL mret_T2 got rd=%b tgt=%h save=%b fl=%b epc=%h want 0 84 0 0 94",
                tif.pc_redirect_o, tif.pc_target_o, tif.save_epc_o, tif.flush_o, tif.epc_pc_o);
        end
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b1) begin n_fail++; $display("FAIL irq_vs_mret_kill got %b want 1", tif.kill_o); end
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.save_epc_o !== 1'b1 || tif.epc_pc_o !== 32'h300 || tif.mcause_o !== IRQC) begin
            n_fail++; $display("FAIL irq_vs_mret got save=%b epc=%h cause=%h want 1 300 %h",
                tif.save_epc_o, tif.epc_pc_o, tif.mcause_o, IRQC);
        end
        @(negedge clk);
        n_checks++;
        if (tif.pc_target_o !== 32'h100) begin
            n_fail++; $display("FAIL irq_vs_mret_tgt got %h want 100", tif.pc_target_o);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int saves;
        int redirects;
        saves = 0;
        redirects = 0;
        drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b1) begin n_fail++; $display("FAIL b2b_T_kill got %b want 1", tif.kill_o); end
        @(negedge clk);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b0 || tif.save_epc_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_T1 got kill=%b save=%b want 0 1", tif.kill_o, tif.save_epc_o);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b0 || tif.pc_redirect_o !== 1'b1 || tif.save_epc_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_T2 got kill=%b rd=%b save=%b want 0 1 0",
                tif.kill_o, tif.pc_redirect_o, tif.save_epc_o);
        end
        @(negedge clk);
        tif.instr_pc_i = 32'h504;
        #1;
        n_checks++;
        if (tif.kill_o !== 1'b1 || tif.save_epc_o !== 1'b0 || tif.pc_redirect_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_T3 got kill=%b save=%b rd=%b want 1 0 0",
                tif.kill_o, tif.save_epc_o, tif.pc_redirect_o);
        end
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.epc_pc_o !== 32'h504 || tif.mcause_o !== IRQC) begin
            n_fail++; $display("FAIL b2b_second got epc=%h cause=%h want 504 %h", tif.epc_pc_o, tif.mcause_o, IRQC);
        end
        for (int i = 0; i < 5; i++) begin
            if (tif.save_epc_o === 1'b1) saves++;
            if (tif.pc_redirect_o === 1'b1) redirects++;
            @(negedge clk);
        end
        n_checks++;
        if (saves != 1 || redirects != 1) begin
            n_fail++; $display("FAIL b2b_once got saves=%0d redirects=%0d want 1 1", saves, redirects);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        quiet();
        n_checks++;
        if (tif.save_epc_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_save got %b want 1", tif.save_epc_o); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({tif.save_epc_o, tif.flush_o, tif.stall_o, tif.pc_redirect_o} !== 4'b0000
            || {tif.epc_pc_o, tif.mcause_o, tif.pc_target_o} !== 96'd0) begin
            n_fail++; $display("FAIL rstmid_after got strobes=%b epc=%h cause=%h tgt=%h want 0",
                {tif.save_epc_o, tif.flush_o, tif.stall_o, tif.pc_redirect_o},
                tif.epc_pc_o, tif.mcause_o, tif.pc_target_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (tif.pc_redirect_o !== 1'b0 || tif.flush_o !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_no_redirect cycle %0d got rd=%b fl=%b want 0 0",
                    i, tif.pc_redirect_o, tif.flush_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_priority();
        test_mret();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that sits directly upstream of the CSR unit in the core. It watches the execute-stage instruction for exceptions (illegal, ecall), external interrupts and `mret`, and then sequences the trap. For a trap it kills the offending instruction, drives the CSR unit's EPC-save strobe with the trapping PC, records `mcause`, flushes the pipeline and redirects fetch to the trap vector. For `mret` it redirects fetch to the EPC supplied by the CSR unit.

## Interface
- `MTVEC`, default `32'h0000_0100`: trap vector; all traps jump here, direct mode only.
- `IRQ_CAUSE`, default `32'h8000_000B`: `mcause` value for an external interrupt.

- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `instr_valid_i`  in  1  a valid instruction occupies the execute stage this cycle.
- `instr_pc_i`  in  32  PC of that instruction.
- `illegal_i`  in  1  the instruction is illegal; qualified by `instr_valid_i`.
- `ecall_i`  in  1  the instruction is `ecall`; qualified by `instr_valid_i`.
- `mret_i`  in  1  the instruction is `mret`; qualified by `instr_valid_i`.
- `irq_i`  in  1  external interrupt request, level-sensitive.
- `mie_i`  in  1  `mstatus.MIE` from the CSR unit.
- `epc_i`  in  32  current `mepc` from the CSR unit.
- `kill_o`  out  1  combinational; suppress writeback of the execute-stage instruction this cycle.
- `save_epc_o`  out  1  registered; EPC-save strobe to the CSR unit.
- `epc_pc_o`  out  32  registered; PC to be saved, connects to the CSR unit's PC input.
- `mcause_o`  out  32  registered; cause of the most recent trap.
- `flush_o`  out  1  registered; invalidate fetch and decode.
- `stall_o`  out  1  registered; hold fetch and execute while a sequence is in progress.
- `pc_redirect_o`  out  1  registered; one-cycle strobe telling fetch to load `pc_target_o`.
- `pc_target_o`  out  32  registered; redirect target.

## Operation
- **States:** IDLE, SAVE, VECTOR, RET.
- **Trap request** (evaluated in IDLE only): `instr_valid_i & ((irq_i & mie_i) | illegal_i | ecall_i)`.
- **Trap priority** when several hold: irq > illegal > ecall.
- **Cause values:**
  - irq: `IRQ_CAUSE`.
  - illegal: `32'd2`.
  - ecall: `32'd11`.
- **Trap request in IDLE, same cycle:**
  - `kill_o`=1.
  - On the next edge: capture `instr_pc_i` into `epc_pc_o`, load the cause into `mcause_o`, go to SAVE.
- **SAVE** (one cycle):
  - `save_epc_o`=1, `flush_o`=1, `stall_o`=1.
  - The CSR unit clears MIE on the same edge.
  - Next state: VECTOR.
- **VECTOR** (one cycle):
  - `pc_redirect_o`=1, `pc_target_o`=`MTVEC`, `flush_o`=1, `stall_o`=1.
  - Next state: IDLE.
- **`mret` in IDLE, when no trap request is present:**
  - `kill_o`=0.
  - On the next edge: latch `epc_i` into `pc_target_o`, go to RET.
- **RET** (one cycle):
  - `pc_redirect_o`=1, `flush_o`=1, `stall_o`=1.
  - Next state: IDLE.
- **Inputs outside IDLE:** all event inputs are ignored in SAVE, VECTOR and RET.
- **Interrupts without a valid instruction:** an interrupt waits until `instr_valid_i`=1, so the saved EPC is always the PC of an unexecuted instruction.
- **Interrupt vs exception:** when irq wins over illegal or ecall, the excepting instruction is not executed. It re-traps after `mret`.
- **Interrupt vs `mret`:** an interrupt coincident with `mret` wins; `mret` is killed and `epc_pc_o` = `mret`'s PC.
- **Masked interrupt:** `irq_i` with `mie_i`=0 has no effect.
- **Output hold:** `epc_pc_o` and `mcause_o` hold their values until the next trap. `pc_target_o` holds its value between redirects.

## Timing
- **Reset:** with `rst_n`=0 at an edge, the next state is IDLE. After that edge:
  - `save_epc_o`, `flush_o`, `stall_o`, `pc_redirect_o` = 0.
  - `epc_pc_o`, `mcause_o`, `pc_target_o` = 0.
  - `kill_o` is undriven-high-free: it is combinational and gated by IDLE.
- **Reset mid-sequence:** no strobe is emitted after the reset edge, and no redirect occurs.
- **Trap latency:** detect at cycle T (`kill_o`), `save_epc_o` at T+1, `pc_redirect_o` at T+2, IDLE at T+3. The earliest next trap detect is T+3.
- **`mret` latency:** detect at T, `pc_redirect_o` at T+1, IDLE at T+2.
- **Strobe width:** `save_epc_o` and `pc_redirect_o` are exactly one cycle wide, never both in the same cycle, and never asserted in IDLE.
- **`stall_o`:** equals `flush_o`; high in every non-IDLE state.
- **`epc_i` sampling:** sampled only on the IDLE→RET edge. Changes during RET do not affect the target.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `irq_i`=1 and `mie_i`=1 → all registered outputs 0 and no strobes. First trap detect occurs in the first cycle with `rst_n`=1.
- **Illegal instruction:** illegal at PC `0x0000_0040` →
  - `kill_o` at T.
  - `save_epc_o`=1 with `epc_pc_o`=`0x40` and `mcause_o`=2 at T+1.
  - `pc_redirect_o`=1 with target `0x100` at T+2.
  - IDLE at T+3.
- **Interrupt vs ecall:** `irq_i`=1, `mie_i`=1 and `ecall_i`=1 at PC `0x80` → `mcause_o`=`0x8000_000B`, `epc_pc_o`=`0x80`. The same scenario with `mie_i`=0 → `mcause_o`=11.
- **`mret`:** `mret` with `epc_i`=`0x0000_0084` → `pc_redirect_o` at T+1 with target `0x84`, `kill_o`=0, `save_epc_o` never asserted. Changing `epc_i` during RET does not change the target.
- **Events ignored mid-sequence:** assert illegal and irq continuously during SAVE/VECTOR → they are ignored. A new detect occurs at T+3 and the strobe sequence repeats exactly once.
- **Reset mid-sequence:** assert `rst_n`=0 during SAVE → no `pc_redirect_o` is ever emitted; state is IDLE and outputs are 0 after the edge.
